sr_cmd_ctrl: RTL and testbench
==============================

# sr_cmd_ctrl

Sequencer that sits directly upstream of the gated SR latch and drives its `s`, `r` and `en` inputs from two raw asynchronous request lines (set button, reset button). It synchronises and debounces each line and turns each debounced rising edge into a clean, fixed-width set or reset pulse. It guarantees the latch never sees `s=r=1` and is always initialised to `q=0` after reset. It also keeps a registered shadow of the commanded latch value for downstream logic.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive identical synchronised samples required to accept a level change (≥1).
- `PULSE_CYCLES`, 2: width of each `s`/`r` pulse in clocks (≥1).
- `GAP_CYCLES`, 3: minimum idle clocks (`s=r=0`) between pulses (≥1).
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `set_in`  in  1  raw set request, asynchronous to `clk`.
- `reset_in`  in  1  raw reset request, asynchronous to `clk`.
- `s`  out  1  latch set input.
- `r`  out  1  latch reset input.
- `en`  out  1  latch enable.
- `busy`  out  1  high in INIT, PULSE and GAP.
- `q_shadow`  out  1  commanded latch value; updates on the first cycle of each pulse.

## Operation
- Each raw input passes through a 2-flop synchroniser and then a debounce counter.
- The debounced level toggles only after `DEBOUNCE_CYCLES` consecutive synchronised samples that differ from the current debounced level. Any agreeing sample clears the counter.
- A registered rising-edge detector on each debounced level produces a one-cycle request. Falling edges are ignored.
- Each channel has a one-deep pending flag, set by its request. A request arriving while that flag is already set is absorbed.
- FSM states:
  - INIT (reset state): `en=1`, `r=1`, `s=0` for `PULSE_CYCLES`, then go to GAP.
  - IDLE: `en=1`, `s=r=0`, which holds the latch.
  - PULSE: drive `s` or `r` for `PULSE_CYCLES`; clear that channel's pending flag on entry.
  - GAP: `s=r=0` for `GAP_CYCLES`, then go to IDLE.
- IDLE → PULSE when any pending flag is set, including one set in that same cycle.
  - Reset has priority when both are pending.
  - The set stays pending and issues after the GAP.
- `s` and `r` are never high together. Both are registered outputs.
- `q_shadow`: 0 at INIT, 1 when a set pulse starts, 0 when a reset pulse starts.
- `en` is 1 in every state after reset deasserts, so the latch never falls into its disabled-forced-clear mode during normal operation.

## Timing
- During reset: `s=0`, `r=0`, `en=0`, `busy=1`, `q_shadow=0`. Synchronisers, counters, debounced levels, pending flags and edge registers are all cleared.
- First rising edge after reset deasserts: enter INIT with outputs `en=1`, `r=1`. INIT lasts `PULSE_CYCLES`, followed by `GAP_CYCLES`.
- Latency: if `set_in` is stable high from before clock edge k and the FSM is IDLE, `s=1` first appears after edge k+`DEBOUNCE_CYCLES`+3 (2 synchroniser stages + debounce + edge register).
- Spacing: a pulse starts at most one cycle after entry to IDLE when a request is pending. Consecutive pulses are exactly `PULSE_CYCLES`+`GAP_CYCLES`+1 clocks apart.
- Glitches shorter than `DEBOUNCE_CYCLES` synchronised samples produce no pulse.
- Reset asserted mid-pulse: outputs clear immediately (asynchronously), pending requests are lost, and the sequence restarts at INIT.

## Structure
- Shared package `sr_pkg`: FSM state enum (INIT, IDLE, PULSE, GAP), default parameter constants, and a counter-width function using `$clog2(max(DEBOUNCE_CYCLES, PULSE_CYCLES, GAP_CYCLES)+1)`.
- Sub-module `sr_debounce`: synchroniser, debounce counter and rising-edge detector, instantiated once per channel.
- The top level holds the pending flags, FSM, pulse/gap counter and `q_shadow`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `PULSE_CYCLES`=2, `GAP_CYCLES`=3.
- Reset release → `r=1`, `en=1` for 2 cycles, then `s=r=0` for 3 cycles. `q_shadow=0` and `busy` falls at cycle 6.
- `set_in` held high from edge 20 (FSM idle) → `s=1` on cycles 27–28, `q_shadow=1` from cycle 27, `r` stays 0.
- `set_in` high for 3 synchronised cycles, then low → no pulse, `q_shadow` unchanged.
- `set_in` and `reset_in` rise on the same edge → `r` pulse first, then `s` pulse starting 6 cycles after the `r` pulse start. `q_shadow` ends at 1. `s&r` is never 1.
- `reset_in` edge during GAP → `r` pulse issues on the cycle after GAP ends. A second `reset_in` edge while it is still pending produces only one pulse.
- `rst` asserted during the second cycle of an `s` pulse → `s=0`, `en=0`, `q_shadow=0` within the same cycle (async). The INIT sequence repeats after release, and no `s` pulse is issued.

Source files
------------

// File: rtl/sr_pkg.sv
// ----------------------------------------------------------------------------
// sr_pkg
// Shared definitions for the SR latch command sequencer:
//   - sr_state_t : sequencer FSM states
//   - sr_chan_t  : which latch input a pulse drives
//   - DEF_*      : default timing parameters
//   - sr_cnt_w() : width of a counter that must reach the largest timing value
// ----------------------------------------------------------------------------
package sr_pkg;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_IDLE  = 2'd1,
      ST_PULSE = 2'd2,
      ST_GAP   = 2'd3
   } sr_state_t;

   typedef enum logic {
      CH_RST = 1'b0,
      CH_SET = 1'b1
   } sr_chan_t;

   localparam int DEF_DEBOUNCE_CYCLES = 4;
   localparam int DEF_PULSE_CYCLES    = 2;
   localparam int DEF_GAP_CYCLES      = 3;

   function automatic int sr_cnt_w(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/sr_debounce.sv
// ----------------------------------------------------------------------------
// sr_debounce
// One request channel: 2-flop synchroniser, debounce counter and registered
// rising-edge detector.
//   clk, rst : clock, asynchronous active-high reset
//   raw      : raw asynchronous request line
//   rise     : one-cycle pulse per accepted (debounced) rising edge
// ----------------------------------------------------------------------------
module sr_debounce #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic rise
);

   logic             sync_p0;
   logic             sync_p1;
   logic [CNT_W-1:0] db_cnt;
   logic             level;
   logic             level_p2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_p0  <= 1'b0;
         sync_p1  <= 1'b0;
         db_cnt   <= '0;
         level    <= 1'b0;
         level_p2 <= 1'b0;
         rise     <= 1'b0;
      end else begin
         // synchroniser stage
         sync_p0 <= raw;
         sync_p1 <= sync_p0;

         // debounce stage: toggle only after DEBOUNCE_CYCLES disagreeing
         // samples in a row; a single agreeing sample restarts the count
         if (sync_p1 != level) begin
            if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
               level  <= sync_p1;
               db_cnt <= '0;
            end else begin
               db_cnt <= db_cnt + 1'b1;
            end
         end else begin
            db_cnt <= '0;
         end

         // edge stage: registered so the request is glitch-free
         level_p2 <= level;
         rise     <= level & ~level_p2;
      end
   end

endmodule

// File: rtl/sr_cmd_ctrl.sv
// ----------------------------------------------------------------------------
// sr_cmd_ctrl
// Drives the s/r/en inputs of a gated SR latch from two raw request buttons.
// Each request becomes a fixed-width s or r pulse separated by an idle gap;
// s and r are never high together and the latch is cleared after reset.
//   clk, rst  : clock, asynchronous active-high reset
//   set_in    : raw set request (asynchronous)
//   reset_in  : raw reset request (asynchronous)
//   s, r, en  : registered latch controls
//   busy      : high in INIT, PULSE and GAP (and during reset)
//   q_shadow  : commanded latch value, updated on the first cycle of a pulse
// ----------------------------------------------------------------------------
module sr_cmd_ctrl
   import sr_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int PULSE_CYCLES    = DEF_PULSE_CYCLES,
   parameter int GAP_CYCLES      = DEF_GAP_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic set_in,
   input  logic reset_in,
   output logic s,
   output logic r,
   output logic en,
   output logic busy,
   output logic q_shadow
);

   localparam int CW    = sr_cnt_w(DEBOUNCE_CYCLES, PULSE_CYCLES, GAP_CYCLES);
   localparam int DB_CW = sr_cnt_w(DEBOUNCE_CYCLES, 1, 1);

   logic req_set;
   logic req_rst;

   sr_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (DB_CW)
   ) u_db_set (
      .clk  (clk),
      .rst  (rst),
      .raw  (set_in),
      .rise (req_set)
   );

   sr_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (DB_CW)
   ) u_db_rst (
      .clk  (clk),
      .rst  (rst),
      .raw  (reset_in),
      .rise (req_rst)
   );

   sr_state_t       state, state_nxt;
   sr_chan_t        chan, chan_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic            pend_set, pend_set_nxt;
   logic            pend_rst, pend_rst_nxt;
   logic            q_nxt;
   logic            s_nxt, r_nxt;

   // The state register holds the phase whose outputs are currently visible,
   // so s/r/busy are registered from the next-state decode. Reset parks the
   // FSM in INIT with en=0; the first clock after release is the first INIT
   // output cycle, which is why INIT does not count while en is still low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_INIT;
         chan     <= CH_RST;
         cnt      <= '0;
         pend_set <= 1'b0;
         pend_rst <= 1'b0;
         s        <= 1'b0;
         r        <= 1'b0;
         en       <= 1'b0;
         busy     <= 1'b1;
         q_shadow <= 1'b0;
      end else begin
         state    <= state_nxt;
         chan     <= chan_nxt;
         cnt      <= cnt_nxt;
         pend_set <= pend_set_nxt;
         pend_rst <= pend_rst_nxt;
         s        <= s_nxt;
         r        <= r_nxt;
         en       <= 1'b1;
         busy     <= (state_nxt != ST_IDLE);
         q_shadow <= q_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      chan_nxt     = chan;
      cnt_nxt      = cnt;
      q_nxt        = q_shadow;
      // a new request ORs into its flag, so a repeat while pending is absorbed
      pend_set_nxt = pend_set | req_set;
      pend_rst_nxt = pend_rst | req_rst;

      case (state)
         ST_INIT: begin
            q_nxt = 1'b0;
            if (!en) begin
               cnt_nxt = '0;
            end else if (cnt == CW'(PULSE_CYCLES - 1)) begin
               state_nxt = ST_GAP;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         ST_IDLE: begin
            // reset wins a tie; the set stays pending for the next slot
            if (pend_rst_nxt) begin
               state_nxt    = ST_PULSE;
               chan_nxt     = CH_RST;
               cnt_nxt      = '0;
               q_nxt        = 1'b0;
               pend_rst_nxt = 1'b0;
            end else if (pend_set_nxt) begin
               state_nxt    = ST_PULSE;
               chan_nxt     = CH_SET;
               cnt_nxt      = '0;
               q_nxt        = 1'b1;
               pend_set_nxt = 1'b0;
            end
         end
         ST_PULSE: begin
            if (cnt == CW'(PULSE_CYCLES - 1)) begin
               state_nxt = ST_GAP;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         ST_GAP: begin
            if (cnt == CW'(GAP_CYCLES - 1)) begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = ST_INIT;
            cnt_nxt   = '0;
         end
      endcase

      s_nxt = (state_nxt == ST_PULSE) && (chan_nxt == CH_SET);
      r_nxt = (state_nxt == ST_INIT) ||
              ((state_nxt == ST_PULSE) && (chan_nxt == CH_RST));
   end

endmodule

// File: tb/tb_sr_cmd_ctrl.sv
module tb_sr_cmd_ctrl;

   logic clk = 1'b0;
   logic rst;
   logic set_in;
   logic reset_in;
   logic s, r, en, busy, q_shadow;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      bit is_set;
      int cyc;
      bit q;
   } pulse_t;

   pulse_t exp_q[$];

   always #5 clk = ~clk;

   sr_cmd_ctrl #(
      .DEBOUNCE_CYCLES (4),
      .PULSE_CYCLES    (2),
      .GAP_CYCLES      (3)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .set_in   (set_in),
      .reset_in (reset_in),
      .s        (s),
      .r        (r),
      .en       (en),
      .busy     (busy),
      .q_shadow (q_shadow)
   );

   // cycle number within the current reset epoch: value after edge n is n
   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cyc %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic push(input bit is_set, input int c, input bit q);
      pulse_t p;
      p.is_set = is_set;
      p.cyc    = c;
      p.q      = q;
      exp_q.push_back(p);
   endtask

   task automatic wait_cyc(input int n);
      int guard;
      guard = 0;
      while (cyc != n) begin
         @(negedge clk);
         guard++;
         if (guard > 1000) begin
            errors++;
            checks++;
            $display("FAIL wait_cyc timeout: got cyc %0d expected %0d", cyc, n);
            return;
         end
      end
   endtask

   // ------------------------------------------------------------------ monitor
   logic s_q, r_q;
   int   s_w, r_w;

   always @(negedge clk) begin
      if (rst || cyc < 1) begin
         s_q = 1'b0;
         r_q = 1'b0;
         s_w = 0;
         r_w = 0;
      end else begin
         check("s_and_r", int'(s & r), 0);
         check("en_high", int'(en), 1);
         if ((s && !s_q) || (r && !r_q)) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pulse: got s=%0d r=%0d at cyc %0d expected none", s, r, cyc);
            end else begin
               pulse_t e;
               e = exp_q.pop_front();
               check("pulse_kind_is_set", int'(s), int'(e.is_set));
               check("pulse_start_cyc", cyc, e.cyc);
               check("pulse_q_shadow", int'(q_shadow), int'(e.q));
            end
         end
         if (s) s_w++;
         if (r) r_w++;
         if (s_q && !s) begin check("s_width", s_w, 2); s_w = 0; end
         if (r_q && !r) begin check("r_width", r_w, 2); r_w = 0; end
         s_q = s;
         r_q = r;
      end
   end

   // --------------------------------------------------------------- stimulus
   initial begin
      rst      = 1'b1;
      set_in   = 1'b0;
      reset_in = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_s", int'(s), 0);
      check("rst_r", int'(r), 0);
      check("rst_en", int'(en), 0);
      check("rst_busy", int'(busy), 1);
      check("rst_q", int'(q_shadow), 0);

      // reset release: INIT r pulse at cycle 1, busy drops at cycle 6
      rst = 1'b0;
      push(1'b0, 1, 1'b0);
      wait_cyc(1);
      check("init_en", int'(en), 1);
      check("init_r", int'(r), 1);
      wait_cyc(5);
      check("gap_busy", int'(busy), 1);
      check("gap_r", int'(r), 0);
      wait_cyc(6);
      check("idle_busy", int'(busy), 0);
      check("idle_q", int'(q_shadow), 0);

      // set_in stable high from edge 20 -> s at 27..28
      push(1'b1, 27, 1'b1);
      wait_cyc(19);
      set_in = 1'b1;
      wait_cyc(28);
      check("set_q", int'(q_shadow), 1);
      wait_cyc(40);
      set_in = 1'b0;

      // glitch of 3 synchronised samples -> nothing
      wait_cyc(60);
      set_in = 1'b1;
      wait_cyc(63);
      set_in = 1'b0;
      wait_cyc(75);
      check("glitch_q", int'(q_shadow), 1);
      check("glitch_busy", int'(busy), 0);

      // both requests on the same edge: r at 87, s at 93
      push(1'b0, 87, 1'b0);
      push(1'b1, 93, 1'b1);
      wait_cyc(79);
      set_in   = 1'b1;
      reset_in = 1'b1;
      wait_cyc(110);
      set_in   = 1'b0;
      reset_in = 1'b0;
      check("both_q", int'(q_shadow), 1);

      // reset request arriving during GAP of a set pulse; short glitch while
      // pending must not add a pulse
      push(1'b1, 137, 1'b1);
      push(1'b0, 143, 1'b0);
      wait_cyc(129);
      set_in = 1'b1;
      wait_cyc(133);
      reset_in = 1'b1;
      wait_cyc(141);
      reset_in = 1'b0;
      wait_cyc(143);
      reset_in = 1'b1;
      wait_cyc(150);
      set_in   = 1'b0;
      reset_in = 1'b0;
      wait_cyc(160);
      check("gap_req_q", int'(q_shadow), 0);

      // async reset during second cycle of an s pulse
      push(1'b1, 177, 1'b1);
      wait_cyc(169);
      set_in = 1'b1;
      wait_cyc(177);
      set_in = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_s", int'(s), 0);
      check("async_en", int'(en), 0);
      check("async_q", int'(q_shadow), 0);
      check("async_busy", int'(busy), 1);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      push(1'b0, 1, 1'b0);
      wait_cyc(6);
      check("re_idle_busy", int'(busy), 0);
      wait_cyc(30);
      check("re_q", int'(q_shadow), 0);
      check("exp_queue_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
